seq_match_counter: RTL and testbench

//  Downstream consumer of the 3-stage JK shift register: samples its parallel window
//  {Q2,Q1,Q0} every CLK edge and detects a programmable bit pattern in the serial stream.

---
 rtl/seq_match_counter.sv | 193 +++++++++++++++++++
 tb/tb_seq_match_counter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_counter.sv
// -----------------------------------------------------------------------------
// seq_match_counter
//
// Watches the parallel window of an upstream WIDTH-stage shift register and
// detects a programmable bit pattern in the serial stream it carries. Matches
// are counted in a saturating counter. Each counted match is also posted as an
// event that stays pending until the consumer acknowledges it.
//
// Window convention: win[0] is the newest bit, win[WIDTH-1] the oldest.
//
// Parameters
//   WIDTH    window width (equals the upstream shift-register depth)
//   PATTERN  value that win must equal for a match
//   OVERLAP  1: overlapping matches count; 0: a match consumes its WIDTH bits
//   CNT_W    width of the match counter
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   en         in   1      upstream register shifted in a new bit this cycle
//   win        in   WIDTH  parallel window from the shift register
//   clr        in   1      synchronous clear of count, sat, ovf and the event
//   match      out  1      registered one-cycle pulse per counted match
//   count      out  CNT_W  matches since reset/clr, saturating
//   sat        out  1      sticky: count reached its maximum
//   evt_valid  out  1      event pending
//   evt_cnt    out  CNT_W  count value captured with the pending event
//   evt_ack    in   1      event completes on evt_valid & evt_ack
//   ovf        out  1      sticky: a match was dropped while an event was pending
// -----------------------------------------------------------------------------
module seq_match_counter #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] PATTERN = 3'b101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] win,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_cnt,
  input  logic             evt_ack,
  output logic             ovf
);

  // Fill and skip counters both range over 0..WIDTH-1.
  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ARM,   // window still holds reset zeros; waiting for WIDTH fresh bits
    ST_HUNT,  // comparing every new window against PATTERN
    ST_HOLD   // non-overlap mode: skipping the bits consumed by the last match
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   skip_q, skip_d;
  logic            hit;
  logic [CNT_W-1:0] count_inc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    fill_d  = fill_q;
    skip_d  = skip_q;
    hit     = 1'b0;

    unique case (state_q)
      ST_ARM: begin
        if (en) begin
          if (fill_q == LAST_IDX) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + CW'(1);
          end
        end
      end

      ST_HUNT: begin
        if (en && (win == PATTERN)) begin
          hit = 1'b1;
          // A single-bit window has nothing to skip, so HOLD is never used.
          if (!OVERLAP && (WIDTH > 1)) begin
            state_d = ST_HOLD;
            skip_d  = LAST_IDX;
          end
        end
      end

      ST_HOLD: begin
        // skip_q counts down the EN edges still to ignore; the last one
        // returns to HUNT so the next compared window is entirely fresh.
        if (en) begin
          if (skip_q == CW'(1)) begin
            state_d = ST_HUNT;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_ARM;
        fill_d  = '0;
        skip_d  = '0;
      end
    endcase

    // Clear wins over a coincident match and abandons any partial HOLD. ARM
    // keeps filling, because the upstream window contents are unaffected.
    if (clr) begin
      hit = 1'b0;
      if (state_q != ST_ARM) begin
        state_d = ST_HUNT;
        skip_d  = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!reset) begin
      state_q <= ST_ARM;
      fill_q  <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      skip_q  <= skip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter, saturation and event handshake
  // ---------------------------------------------------------------------------
  // Saturating increment: once at the maximum the counter holds.
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match     <= 1'b0;
      count     <= '0;
      sat       <= 1'b0;
      evt_valid <= 1'b0;
      evt_cnt   <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      match     <= 1'b0;
      count     <= '0;
      sat       <= 1'b0;
      evt_valid <= 1'b0;
      evt_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      match <= hit;
      if (hit) begin
        count <= count_inc;
        if (count_inc == CNT_MAX) begin
          sat <= 1'b1;
        end
        // The slot is free if nothing is pending or the pending event is
        // being acknowledged on this very edge; otherwise the new event is
        // dropped and the overflow flag records the loss.
        if (!evt_valid || evt_ack) begin
          evt_valid <= 1'b1;
          evt_cnt   <= count_inc;
        end else begin
          ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ack) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_counter.sv
// -----------------------------------------------------------------------------
// tb_seq_match_counter
//
// Three instances share one stimulus stream:
//   0: PATTERN=101, OVERLAP=1     1: PATTERN=101, OVERLAP=0
//   2: PATTERN=000, OVERLAP=1
// Each clock edge the stimulus advances a behavioural model of every instance
// and pushes the expected outputs into a queue; a monitor pops on the falling
// edge and compares. Directed sequences add absolute checks on top.
// -----------------------------------------------------------------------------
module tb_seq_match_counter;

  localparam int W    = 3;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] win = '0;
  logic       clr = 1'b0;
  logic       evt_ack = 1'b0;

  logic       match_o     [3];
  logic [3:0] count_o     [3];
  logic       sat_o       [3];
  logic       evt_valid_o [3];
  logic [3:0] evt_cnt_o   [3];
  logic       ovf_o       [3];

  always #5 clk = ~clk;

  seq_match_counter #(.WIDTH(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .win(win), .clr(clr),
    .match(match_o[0]), .count(count_o[0]), .sat(sat_o[0]),
    .evt_valid(evt_valid_o[0]), .evt_cnt(evt_cnt_o[0]), .evt_ack(evt_ack), .ovf(ovf_o[0]));

  seq_match_counter #(.WIDTH(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .win(win), .clr(clr),
    .match(match_o[1]), .count(count_o[1]), .sat(sat_o[1]),
    .evt_valid(evt_valid_o[1]), .evt_cnt(evt_cnt_o[1]), .evt_ack(evt_ack), .ovf(ovf_o[1]));

  seq_match_counter #(.WIDTH(3), .PATTERN(3'b000), .OVERLAP(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .en(en), .win(win), .clr(clr),
    .match(match_o[2]), .count(count_o[2]), .sat(sat_o[2]),
    .evt_valid(evt_valid_o[2]), .evt_cnt(evt_cnt_o[2]), .evt_ack(evt_ack), .ovf(ovf_o[2]));

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_out(input int i);
    return {match_o[i], count_o[i], sat_o[i], evt_valid_o[i], evt_cnt_o[i], ovf_o[i]};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: tracks how many EN edges remain before the window is
  // fully fresh, how many bits a non-overlapping match still owns, the total
  // number of matches since clear, and the single-entry event slot.
  // ---------------------------------------------------------------------------
  typedef struct {
    int fill_left;
    int skip_left;
    int total;
    bit match;
    bit ev;
    int ev_cnt;
    bit ovf;
  } model_t;

  model_t     mdl [3];
  logic [2:0] mdl_pat [3];
  bit         mdl_ovl [3];

  function automatic model_t model_reset();
    model_t m;
    m.fill_left = W;
    m.skip_left = 0;
    m.total     = 0;
    m.match     = 1'b0;
    m.ev        = 1'b0;
    m.ev_cnt    = 0;
    m.ovf       = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic e, input logic [2:0] w,
                                        input logic c, input logic a,
                                        input logic [2:0] pat, input bit ovl);
    bit hit = 1'b0;
    int shown;
    if (e) begin
      if (m.fill_left > 0)      m.fill_left--;
      else if (m.skip_left > 0) m.skip_left--;
      else if (w == pat)        hit = 1'b1;
    end
    if (c) begin
      m.skip_left = 0;
      m.total     = 0;
      m.match     = 1'b0;
      m.ev        = 1'b0;
      m.ev_cnt    = 0;
      m.ovf       = 1'b0;
    end else begin
      m.match = hit;
      if (hit) begin
        m.total++;
        if (!ovl) m.skip_left = W - 1;
        shown = (m.total > CMAX) ? CMAX : m.total;
        if (!m.ev || a) begin
          m.ev     = 1'b1;
          m.ev_cnt = shown;
        end else begin
          m.ovf = 1'b1;
        end
      end else if (m.ev && a) begin
        m.ev = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic [11:0] model_out(input model_t m);
    int shown = (m.total > CMAX) ? CMAX : m.total;
    return {m.match, 4'(shown), (m.total >= CMAX), m.ev, 4'(m.ev_cnt), m.ovf};
  endfunction

  // Expected outputs of all three instances after one edge, newest at back.
  logic [35:0] exp_q [$];

  // ---------------------------------------------------------------------------
  // Monitor: compares what the DUTs present against the queued expectation.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [35:0] e;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d outputs", i), 32'(dut_out(i)), 32'(e[i*12 +: 12]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [1:0] sr = '0;  // two most recent upstream bits

  task automatic cycle(input logic e, input logic [2:0] w, input logic c, input logic a);
    logic [35:0] e_all;
    en      = e;
    win     = w;
    clr     = c;
    evt_ack = a;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mdl[i] = model_step(mdl[i], e, w, c, a, mdl_pat[i], mdl_ovl[i]);
      e_all[i*12 +: 12] = model_out(mdl[i]);
    end
    exp_q.push_back(e_all);
    @(negedge clk);
  endtask

  // Shift one serial bit through the upstream register and present the window.
  task automatic shift_bit(input logic b, input logic a);
    logic [2:0] w;
    w  = {sr, b};
    sr = w[1:0];
    cycle(1'b1, w, 1'b0, a);
  endtask

  // Asynchronous reset, asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s async reset dut%0d", tag, i), 32'(dut_out(i)), 32'h0);
    end
    for (int i = 0; i < 3; i++) mdl[i] = model_reset();
    sr      = '0;
    en      = 1'b0;
    clr     = 1'b0;
    evt_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill_zeros();
    for (int k = 0; k < W; k++) shift_bit(1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pulses;
    mdl_pat[0] = 3'b101; mdl_ovl[0] = 1'b1;
    mdl_pat[1] = 3'b101; mdl_ovl[1] = 1'b0;
    mdl_pat[2] = 3'b000; mdl_ovl[2] = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = model_reset();

    @(negedge clk);
    do_reset("init");

    // All-zero pattern: the reset zeros must not match while arming.
    for (int k = 1; k <= 5; k++) begin
      shift_bit(1'b0, 1'b0);
      check($sformatf("zero-pattern match edge %0d", k), 32'(match_o[2]), (k >= 4) ? 32'd1 : 32'd0);
    end
    check("zero-pattern count", 32'(count_o[2]), 32'd2);

    // Serial 1,0,1,0,1 after a fresh fill: overlap sees two matches, non-overlap one.
    do_reset("serial");
    fill_zeros();
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    check("overlap count", 32'(count_o[0]), 32'd2);
    check("non-overlap count", 32'(count_o[1]), 32'd1);

    // Two un-acked matches, then a match coinciding with the acknowledge.
    do_reset("event");
    fill_zeros();
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    check("unacked evt_cnt", 32'(evt_cnt_o[0]), 32'd1);
    check("unacked ovf", 32'(ovf_o[0]), 32'd1);
    check("unacked count", 32'(count_o[0]), 32'd2);
    cycle(1'b1, 3'b101, 1'b0, 1'b1);
    check("ack+match evt_valid", 32'(evt_valid_o[0]), 32'd1);
    check("ack+match evt_cnt", 32'(evt_cnt_o[0]), 32'd3);
    check("ack+match ovf", 32'(ovf_o[0]), 32'd1);

    // Window held at the pattern while EN toggles: only EN edges count.
    cycle(1'b1, 3'b101, 1'b0, 1'b1);
    cycle(1'b0, 3'b101, 1'b0, 1'b1);
    cycle(1'b1, 3'b101, 1'b0, 1'b1);
    cycle(1'b0, 3'b101, 1'b0, 1'b1);
    check("en gating count", 32'(count_o[0]), 32'd5);

    // Saturation: 18 acknowledged matches.
    do_reset("sat");
    fill_zeros();
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      cycle(1'b1, 3'b101, 1'b0, 1'b1);
      if (match_o[0]) pulses++;
    end
    check("sat count", 32'(count_o[0]), 32'd15);
    check("sat flag", 32'(sat_o[0]), 32'd1);
    check("sat pulses", 32'(pulses), 32'd18);

    // Clear coinciding with a match, then reset in the middle of HOLD.
    do_reset("clr");
    fill_zeros();
    for (int k = 0; k < 7; k++) cycle(1'b1, 3'b101, 1'b0, 1'b1);
    check("pre-clr count", 32'(count_o[0]), 32'd7);
    cycle(1'b1, 3'b101, 1'b1, 1'b0);
    check("clr count", 32'(count_o[0]), 32'd0);
    check("clr match", 32'(match_o[0]), 32'd0);
    check("clr evt_valid", 32'(evt_valid_o[0]), 32'd0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    check("hold entry match", 32'(match_o[1]), 32'd1);
    do_reset("mid-hold");
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    check("rearm count", 32'(count_o[1]), 32'd0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    check("rearm first match", 32'(count_o[1]), 32'd1);

    // Randomized traffic: mostly a real serial stream, with garbage windows
    // on idle cycles, occasional clears and the odd asynchronous reset.
    for (int n = 0; n < 600; n++) begin
      logic       b, e, c, a;
      logic [2:0] w;
      b = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      a = 1'($urandom_range(0, 1));
      if (e) begin
        w  = {sr, b};
        sr = w[1:0];
      end else begin
        w = 3'($urandom_range(0, 7));
      end
      cycle(e, w, c, a);
      if ($urandom_range(0, 199) == 0) do_reset("random");
    end

    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
